// File: rtl/uart_arb_pkg.sv
// Shared constants for the UART transmit arbiter: FSM encoding and tag byte base.
package uart_arb_pkg;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] WAIT_DONE = 3'd2;
    localparam logic [2:0] TAG_START = 3'd3;
    localparam logic [2:0] TAG_WAIT  = 3'd4;

    localparam logic [7:0] TAG_BASE_DEFAULT = 8'hF0;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr_i, wrapping.
module uart_rr_pick #(
    parameter int NUM_REQUESTERS = 4,
    parameter int ID_WIDTH       = $clog2(NUM_REQUESTERS)
) (
    input  logic [NUM_REQUESTERS-1:0] req_i,
    input  logic [ID_WIDTH-1:0]       ptr_i,
    output logic [ID_WIDTH-1:0]       winner_o,
    output logic                      valid_o
);

    logic [ID_WIDTH:0] idx;

    // Scan from the farthest offset down so the closest match to ptr_i wins;
    // the extra index bit keeps non-power-of-2 wrap exact.
    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        idx      = '0;
        for (int off = NUM_REQUESTERS - 1; off >= 0; off--) begin
            idx = {1'b0, ptr_i} + (ID_WIDTH + 1)'(off);
            if (idx >= (ID_WIDTH + 1)'(NUM_REQUESTERS)) begin
                idx = idx - (ID_WIDTH + 1)'(NUM_REQUESTERS);
            end
            if (req_i[idx[ID_WIDTH-1:0]]) begin
                winner_o = idx[ID_WIDTH-1:0];
                valid_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX core among several byte sources.
// Define UART_ARB_TAG_EN to precede each data byte with a TAG_BASE+channel tag byte.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQUESTERS = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int ID_WIDTH       = $clog2(NUM_REQUESTERS)
`ifdef UART_ARB_TAG_EN
    , parameter logic [DATA_WIDTH-1:0] TAG_BASE = DATA_WIDTH'(TAG_BASE_DEFAULT)
`endif
) (
    input  logic                                 IN_CLOCK,
    input  logic                                 IN_RESET,
    input  logic [NUM_REQUESTERS-1:0]            IN_REQ,
    input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0] IN_REQ_DATA,
    output logic [NUM_REQUESTERS-1:0]            OUT_ACK,
    output logic [ID_WIDTH-1:0]                  OUT_GRANT_ID,
    output logic                                 OUT_BUSY,
    output logic                                 OUT_TX_START,
    output logic [DATA_WIDTH-1:0]                OUT_TX_DATA,
    input  logic                                 IN_TX_BUSY,
    input  logic                                 IN_TX_DONE
);

    logic [2:0]                state_q,   state_d;
    logic [ID_WIDTH-1:0]       ptr_q,     ptr_d;
    logic [ID_WIDTH-1:0]       grantId_q, grantId_d;
    logic [NUM_REQUESTERS-1:0] ack_q,     ack_d;
    logic                      busy_q,    busy_d;
    logic                      txStart_q, txStart_d;
    logic [DATA_WIDTH-1:0]     txData_q,  txData_d;
    logic [DATA_WIDTH-1:0]     data_q,    data_d;

    logic [ID_WIDTH-1:0] winner;
    logic                winnerValid;
    logic [ID_WIDTH:0]   ptrNext;

    uart_rr_pick #(
        .NUM_REQUESTERS (NUM_REQUESTERS),
        .ID_WIDTH       (ID_WIDTH)
    ) picker (
        .req_i    (IN_REQ),
        .ptr_i    (ptr_q),
        .winner_o (winner),
        .valid_o  (winnerValid)
    );

    always_comb begin
        ptrNext = {1'b0, winner} + (ID_WIDTH + 1)'(1);
        if (ptrNext == (ID_WIDTH + 1)'(NUM_REQUESTERS)) begin
            ptrNext = '0;
        end
    end

    // TX data is loaded at grant so it is already stable when the start pulse goes out.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grantId_d = grantId_q;
        ack_d     = '0;
        txStart_d = 1'b0;
        txData_d  = txData_q;
        data_d    = data_q;
        case (state_q)
            IDLE: begin
                if (winnerValid) begin
                    data_d        = IN_REQ_DATA[winner*DATA_WIDTH +: DATA_WIDTH];
                    grantId_d     = winner;
                    ack_d[winner] = 1'b1;
                    ptr_d         = ptrNext[ID_WIDTH-1:0];
`ifdef UART_ARB_TAG_EN
                    txData_d      = TAG_BASE + DATA_WIDTH'(winner);
                    state_d       = TAG_START;
`else
                    txData_d      = IN_REQ_DATA[winner*DATA_WIDTH +: DATA_WIDTH];
                    state_d       = START;
`endif
                end
            end
`ifdef UART_ARB_TAG_EN
            TAG_START: begin
                if (!IN_TX_BUSY) begin
                    txStart_d = 1'b1;
                    state_d   = TAG_WAIT;
                end
            end
            TAG_WAIT: begin
                if (IN_TX_DONE) begin
                    state_d = START;
                end
            end
`endif
            START: begin
                if (!IN_TX_BUSY) begin
                    txData_d  = data_q;
                    txStart_d = 1'b1;
                    state_d   = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (IN_TX_DONE) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge IN_CLOCK) begin
        if (IN_RESET) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            grantId_q <= '0;
            ack_q     <= '0;
            busy_q    <= 1'b0;
            txStart_q <= 1'b0;
            txData_q  <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grantId_q <= grantId_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            txStart_q <= txStart_d;
            txData_q  <= txData_d;
            data_q    <= data_d;
        end
    end

    assign OUT_ACK      = ack_q;
    assign OUT_GRANT_ID = grantId_q;
    assign OUT_BUSY     = busy_q;
    assign OUT_TX_START = txStart_q;
    assign OUT_TX_DATA  = txData_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a 4-channel instance driven from a vector
// table and hand sequences, plus a 3-channel instance for non-power-of-2 wrap.
module tb_uart_tx_arbiter;
    import uart_arb_pkg::*;

`ifdef UART_ARB_TAG_EN
    localparam bit TAG_MODE = 1'b1;
`else
    localparam bit TAG_MODE = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;

    logic [3:0]  req;
    logic [31:0] reqData;
    logic [3:0]  ack;
    logic [1:0]  grantId;
    logic        busy;
    logic        txStart;
    logic [7:0]  txData;
    logic        txBusy;
    logic        txDone;

    logic [2:0]  reqB;
    logic [23:0] reqDataB;
    logic [2:0]  ackB;
    logic [1:0]  grantIdB;
    logic        busyB;
    logic        txStartB;
    logic [7:0]  txDataB;
    logic        txBusyB;
    logic        txDoneB;

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  expAck;
        logic [1:0]  expGrant;
        logic [7:0]  expByte;
    } vector_t;

    vector_t vectors[11];

    always #5 clock = ~clock;

    uart_tx_arbiter #(
        .NUM_REQUESTERS (4),
        .DATA_WIDTH     (8)
    ) dut (
        .IN_CLOCK     (clock),
        .IN_RESET     (reset),
        .IN_REQ       (req),
        .IN_REQ_DATA  (reqData),
        .OUT_ACK      (ack),
        .OUT_GRANT_ID (grantId),
        .OUT_BUSY     (busy),
        .OUT_TX_START (txStart),
        .OUT_TX_DATA  (txData),
        .IN_TX_BUSY   (txBusy),
        .IN_TX_DONE   (txDone)
    );

    uart_tx_arbiter #(
        .NUM_REQUESTERS (3),
        .DATA_WIDTH     (8)
    ) dutB (
        .IN_CLOCK     (clock),
        .IN_RESET     (reset),
        .IN_REQ       (reqB),
        .IN_REQ_DATA  (reqDataB),
        .OUT_ACK      (ackB),
        .OUT_GRANT_ID (grantIdB),
        .OUT_BUSY     (busyB),
        .OUT_TX_START (txStartB),
        .OUT_TX_DATA  (txDataB),
        .IN_TX_BUSY   (txBusyB),
        .IN_TX_DONE   (txDoneB)
    );

    // Byte expected on the first start pulse of a grant: the tag when tagging is built in.
    function automatic logic [7:0] firstByte(input logic [1:0] chan, input logic [7:0] dataByte);
        return TAG_MODE ? (TAG_BASE_DEFAULT + 8'(chan)) : dataByte;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic waitStart(input string name);
        bit found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clock); #1;
            if (txStart) found = 1'b1;
        end
        checkOutput(name, 32'(found), 32'd1);
    endtask

    task automatic waitStartB(input string name);
        bit found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clock); #1;
            if (txStartB) found = 1'b1;
        end
        checkOutput(name, 32'(found), 32'd1);
    endtask

    task automatic pulseDone();
        @(negedge clock);
        txDone = 1'b1;
        @(negedge clock);
        txDone = 1'b0;
    endtask

    // Called after the first start pulse of a grant was checked; ends in IDLE.
    task automatic finishTransfer(input logic [7:0] dataByte);
`ifdef UART_ARB_TAG_EN
        pulseDone();
        waitStart("dataStartAfterTag");
        checkOutput("dataByteAfterTag", 32'(txData), 32'(dataByte));
`endif
        @(negedge clock);
        txDone = 1'b1;
        @(posedge clock); #1;
        checkOutput("busyAfterDone", 32'(busy), 32'd0);
        checkOutput("startLowAtDone", 32'(txStart), 32'd0);
        checkOutput("dataHeldToDone", 32'(txData), 32'(dataByte));
        @(negedge clock);
        txDone = 1'b0;
    endtask

    task automatic applyStimulus(input vector_t v);
        @(negedge clock);
        req     = v.req;
        reqData = v.data;
    endtask

    task automatic checkVector(input int n, input vector_t v);
        @(posedge clock); #1;
        checkOutput($sformatf("vec%0d.ack", n), 32'(ack), 32'(v.expAck));
        checkOutput($sformatf("vec%0d.grant", n), 32'(grantId), 32'(v.expGrant));
        checkOutput($sformatf("vec%0d.busy", n), 32'(busy), 32'd1);
        @(negedge clock);
        req = '0;
        @(posedge clock); #1;
        checkOutput($sformatf("vec%0d.start", n), 32'(txStart), 32'd1);
        checkOutput($sformatf("vec%0d.txData", n), 32'(txData), 32'(firstByte(v.expGrant, v.expByte)));
        checkOutput($sformatf("vec%0d.ackPulse", n), 32'(ack), 32'd0);
        finishTransfer(v.expByte);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vectors[0]  = '{4'b1111, 32'h13121110, 4'b0001, 2'd0, 8'h10};
        vectors[1]  = '{4'b1111, 32'h13121110, 4'b0010, 2'd1, 8'h11};
        vectors[2]  = '{4'b1111, 32'h13121110, 4'b0100, 2'd2, 8'h12};
        vectors[3]  = '{4'b1111, 32'h13121110, 4'b1000, 2'd3, 8'h13};
        vectors[4]  = '{4'b1111, 32'h13121110, 4'b0001, 2'd0, 8'h10};
        vectors[5]  = '{4'b0100, 32'h13A51110, 4'b0100, 2'd2, 8'hA5};
        vectors[6]  = '{4'b0011, 32'h13121155, 4'b0001, 2'd0, 8'h55};
        vectors[7]  = '{4'b1001, 32'hC3121110, 4'b1000, 2'd3, 8'hC3};
        vectors[8]  = '{4'b0110, 32'h1312E710, 4'b0010, 2'd1, 8'hE7};
        vectors[9]  = '{4'b0001, 32'h1312113C, 4'b0001, 2'd0, 8'h3C};
        vectors[10] = '{4'b1000, 32'h5A121110, 4'b1000, 2'd3, 8'h5A};

        reset    = 1'b1;
        req      = '0;
        reqData  = '0;
        txBusy   = 1'b0;
        txDone   = 1'b0;
        reqB     = '0;
        reqDataB = '0;
        txBusyB  = 1'b0;
        txDoneB  = 1'b0;

        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset.ack", 32'(ack), 32'd0);
        checkOutput("reset.grant", 32'(grantId), 32'd0);
        checkOutput("reset.busy", 32'(busy), 32'd0);
        checkOutput("reset.start", 32'(txStart), 32'd0);
        checkOutput("reset.txData", 32'(txData), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        for (int n = 0; n < 11; n++) begin
            applyStimulus(vectors[n]);
            checkVector(n, vectors[n]);
        end

        // TX core busy at grant, plus a request arriving mid-transfer.
        @(negedge clock);
        txBusy  = 1'b1;
        req     = 4'b0010;
        reqData = 32'h00007766;
        @(posedge clock); #1;
        checkOutput("busyHeld.ack", 32'(ack), 32'b0010);
        checkOutput("busyHeld.grant", 32'(grantId), 32'd1);
        @(negedge clock);
        req = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            checkOutput($sformatf("busyHeld.startWithheld%0d", i), 32'(txStart), 32'd0);
            checkOutput($sformatf("busyHeld.noAckMidTransfer%0d", i), 32'(ack), 32'd0);
        end
        @(negedge clock);
        txBusy = 1'b0;
        @(posedge clock); #1;
        checkOutput("busyHeld.start", 32'(txStart), 32'd1);
        checkOutput("busyHeld.txData", 32'(txData), 32'(firstByte(2'd1, 8'h77)));
        @(posedge clock); #1;
        checkOutput("busyHeld.startOnce", 32'(txStart), 32'd0);
        finishTransfer(8'h77);
        @(posedge clock); #1;
        checkOutput("nextGrant.ack", 32'(ack), 32'b0001);
        checkOutput("nextGrant.grant", 32'(grantId), 32'd0);
        @(negedge clock);
        req = '0;
        @(posedge clock); #1;
        checkOutput("nextGrant.start", 32'(txStart), 32'd1);
        checkOutput("nextGrant.txData", 32'(txData), 32'(firstByte(2'd0, 8'h66)));
        finishTransfer(8'h66);

        // Reset while the TX core is still busy with a byte in flight.
        @(negedge clock);
        req     = 4'b0100;
        reqData = 32'h00AB0000;
        @(posedge clock); #1;
        checkOutput("preReset.grant", 32'(grantId), 32'd2);
        @(negedge clock);
        req = '0;
        @(posedge clock); #1;
        checkOutput("preReset.start", 32'(txStart), 32'd1);
        @(negedge clock);
        txBusy = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        checkOutput("midReset.ack", 32'(ack), 32'd0);
        checkOutput("midReset.grant", 32'(grantId), 32'd0);
        checkOutput("midReset.busy", 32'(busy), 32'd0);
        checkOutput("midReset.start", 32'(txStart), 32'd0);
        checkOutput("midReset.txData", 32'(txData), 32'd0);
        @(negedge clock);
        reset   = 1'b0;
        req     = 4'b1001;
        reqData = 32'hDD0000CC;
        @(posedge clock); #1;
        checkOutput("postReset.ptrGrant", 32'(grantId), 32'd0);
        checkOutput("postReset.ack", 32'(ack), 32'b0001);
        @(negedge clock);
        req = '0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clock); #1;
            checkOutput($sformatf("postReset.startWithheld%0d", i), 32'(txStart), 32'd0);
        end
        @(negedge clock);
        txBusy = 1'b0;
        @(posedge clock); #1;
        checkOutput("postReset.start", 32'(txStart), 32'd1);
        checkOutput("postReset.txData", 32'(txData), 32'(firstByte(2'd0, 8'hCC)));
        finishTransfer(8'hCC);

        // Three-channel instance: channels 0 and 2 held, grants must alternate.
        @(negedge clock);
        reqB     = 3'b101;
        reqDataB = 24'h223311;
        for (int g = 0; g < 4; g++) begin
            logic [1:0] expChan;
            logic [7:0] expByte;
            bit         granted;
            expChan = (g % 2 == 0) ? 2'd0 : 2'd2;
            expByte = (g % 2 == 0) ? 8'h11 : 8'h22;
            granted = 1'b0;
            for (int i = 0; i < 10 && !granted; i++) begin
                @(posedge clock); #1;
                if (ackB != '0) granted = 1'b1;
            end
            checkOutput($sformatf("rr3.grant%0d.seen", g), 32'(granted), 32'd1);
            checkOutput($sformatf("rr3.grant%0d.id", g), 32'(grantIdB), 32'(expChan));
            checkOutput($sformatf("rr3.grant%0d.ack", g), 32'(ackB), (g % 2 == 0) ? 32'b001 : 32'b100);
            waitStartB($sformatf("rr3.grant%0d.start", g));
            checkOutput($sformatf("rr3.grant%0d.txData", g), 32'(txDataB), 32'(firstByte(expChan, expByte)));
`ifdef UART_ARB_TAG_EN
            @(negedge clock);
            txDoneB = 1'b1;
            @(negedge clock);
            txDoneB = 1'b0;
            waitStartB($sformatf("rr3.grant%0d.dataStart", g));
            checkOutput($sformatf("rr3.grant%0d.dataByte", g), 32'(txDataB), 32'(expByte));
`endif
            @(negedge clock);
            txDoneB = 1'b1;
            @(negedge clock);
            txDoneB = 1'b0;
        end
        reqB = '0;

        repeat (3) @(posedge clock);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter sharing one UART transmitter core between NUM_REQUESTERS byte sources. Sits between the requesting blocks and the single TX serializer. Accepts one byte per grant, sequences the transmitter's start/busy/done handshake, and rotates priority so no requester starves.

## Interface
- NUM_REQUESTERS, 4: number of request channels, from 2 to 16.
- DATA_WIDTH, 8: byte width; must match the TX core's data width.
- ID_WIDTH, $clog2(NUM_REQUESTERS): width of the grant index.
- TAG_BASE, 8'hF0: base value of the tag byte; used only with UART_ARB_TAG_EN.

Ports:
- IN_CLOCK  in  1: sole clock.
- IN_RESET  in  1: synchronous, active-high reset.
- IN_REQ  in  NUM_REQUESTERS: request per channel. Held high until the matching OUT_ACK.
- IN_REQ_DATA  in  NUM_REQUESTERS*DATA_WIDTH: channel i byte at bits [i*DATA_WIDTH +: DATA_WIDTH]. Held stable while IN_REQ[i] is high.
- OUT_ACK  out  NUM_REQUESTERS: one-cycle pulse; the byte was latched.
- OUT_GRANT_ID  out  ID_WIDTH: index of the current or last granted channel.
- OUT_BUSY  out  1: high in every state except IDLE.
- OUT_TX_START  out  1: one-cycle start pulse to the TX core.
- OUT_TX_DATA  out  DATA_WIDTH: byte to the TX core. Stable from grant until done.
- IN_TX_BUSY  in  1: TX core is serializing.
- IN_TX_DONE  in  1: one-cycle pulse when the TX core's stop bit completes.

## Operation
- States: IDLE, START, WAIT_DONE. With UART_ARB_TAG_EN, TAG_START and TAG_WAIT are added.
- Round-robin pointer PTR (ID_WIDTH bits, reset 0):
  - The winner is the first asserted IN_REQ index found scanning PTR, PTR+1, … with wrap modulo NUM_REQUESTERS.
  - After a grant, PTR = winner+1, wrapping to 0 past NUM_REQUESTERS-1.
- IDLE:
  - If no request: stay in IDLE.
  - If any request: latch the winner's byte into a data register. Set OUT_GRANT_ID = winner and pulse OUT_ACK[winner]. Update PTR. Go to START (or TAG_START with the macro).
- START: when IN_TX_BUSY=0, load OUT_TX_DATA, pulse OUT_TX_START, and go to WAIT_DONE. Otherwise wait in START.
- WAIT_DONE: on IN_TX_DONE, go to IDLE. IN_TX_DONE seen in any other state is ignored.
- IN_REQ is sampled only in IDLE. Requests arriving mid-transfer are served at the next arbitration.
- A requester that drops IN_REQ before its ACK simply loses that arbitration round.
- Simultaneous requests: exactly one OUT_ACK bit per grant; never more than one bit high.
- PTR arithmetic is done in ID_WIDTH+1 bits, then reduced, so non-power-of-2 NUM_REQUESTERS wraps correctly.

## Timing
- Reset values: OUT_ACK=0, OUT_GRANT_ID=0, OUT_BUSY=0, OUT_TX_START=0, OUT_TX_DATA=0, PTR=0, state=IDLE.
- Request high at edge k (state IDLE):
  - OUT_ACK and OUT_GRANT_ID are valid after edge k.
  - OUT_TX_START is high after edge k+1 if IN_TX_BUSY=0.
- IN_TX_DONE at edge d returns the block to IDLE after d. The next grant occurs at edge d+1 at the earliest, so there is a minimum of one IDLE cycle between bytes.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset mid-transfer: outputs and state return to reset values immediately. The TX core is not aborted. The next START waits for IN_TX_BUSY=0, so the in-flight byte completes undisturbed.

## Configuration
- Macro UART_ARB_TAG_EN.
- Defined: each grant sends two bytes.
  - First the tag byte TAG_BASE + winner: TAG_START waits for !IN_TX_BUSY, then pulses start; TAG_WAIT waits for IN_TX_DONE.
  - Then the data byte via START/WAIT_DONE.
  - OUT_ACK timing is unchanged (pulsed at grant).
- Undefined: the tag states and TAG_BASE logic are absent, and each grant sends only the data byte.

## Structure
- Package uart_arb_pkg holds:
  - the state encoding localparams (IDLE=0, START=1, WAIT_DONE=2, TAG_START=3, TAG_WAIT=4);
  - the TAG_BASE default.
- Sub-module uart_rr_pick: combinational round-robin picker. Inputs: request vector and PTR. Outputs: winner index and a valid flag. Instantiated once.

## Test plan
- Single request: IN_REQ=4'b0100, data 8'hA5.
  - Expect OUT_ACK=4'b0100 one cycle later and OUT_GRANT_ID=2.
  - Expect OUT_TX_START with OUT_TX_DATA=8'hA5 one cycle after that.
  - After a DONE pulse, expect OUT_BUSY to fall.
- All four requesting continuously, each byte 8'h10+i: grants in order 0,1,2,3,0, with exactly one ACK bit per grant.
- TX core held busy at grant: expect OUT_TX_START withheld until IN_TX_BUSY falls, then pulsed exactly once.
- IN_RESET asserted during WAIT_DONE with IN_TX_BUSY=1: expect all outputs 0 and PTR=0. A new request gets its start only after busy deasserts.
- UART_ARB_TAG_EN defined, request on channel 3 with 8'h42: expect the TX byte sequence 8'hF3 then 8'h42, and a single ACK.
- NUM_REQUESTERS=3 with channels 0 and 2 requesting: grants alternate 0,2,0,2 and never select index 3.
